// File: rtl/mp64_dma_arb.sv
// Round-robin DMA arbiter sharing one byte-wide memory-bus port between N_REQ masters,
// with burst locking, a dead cycle after every completion and an ack-timeout watchdog.
module mp64_dma_arb #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     m_req,
  input  logic [64*N_REQ-1:0]  m_addr,
  input  logic [8*N_REQ-1:0]   m_wdata,
  input  logic [N_REQ-1:0]     m_wen,
  output logic [N_REQ-1:0]     m_ack,
  output logic                 m_err,
  output logic [7:0]           m_rdata,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic                 timeout_flag,
  input  logic                 clr_flags,
  output logic                 mem_req,
  output logic [63:0]          mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wen,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  burst_q, burst_d;
  logic        have_q, have_d;
  logic        drop_q, drop_d;

  logic [N_REQ-1:0] ack_d;
  logic        err_d, mem_req_d, busy_d, wen_d, flag_d;
  logic [7:0]  rdata_d, wdata_d;
  logic [63:0] addr_d;
  logic [2:0]  grant_d;

  // Per-port buses padded to 8 entries so a 3-bit index is always in range.
  logic [7:0]  req8, wen8;
  logic [63:0] addr_a [8];
  logic [7:0]  wd_a   [8];

  assign req8 = 8'(m_req);
  assign wen8 = 8'(m_wen);

  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < N_REQ) begin : g_on
      assign addr_a[i] = m_addr[64*i +: 64];
      assign wd_a[i]   = m_wdata[8*i +: 8];
    end else begin : g_off
      assign addr_a[i] = '0;
      assign wd_a[i]   = '0;
    end
  end

  // Rotating scan starting just after the current grant; the current grant comes last.
  logic [3:0] cand;
  logic       found;
  logic [2:0] pick;
  always_comb begin
    found = 1'b0;
    pick  = grant;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, grant} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!found && req8[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  // The reset value of grant is not a real owner, so it gets no burst lock.
  logic       lock;
  logic [2:0] win;
  logic       drop_now;
  assign lock     = have_q && req8[grant] && (burst_q < 8'(MAX_BURST));
  assign win      = lock ? grant : pick;
  assign drop_now = drop_q | ~req8[grant];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    burst_d   = burst_q;
    have_d    = have_q;
    drop_d    = drop_q;
    grant_d   = grant;
    mem_req_d = mem_req;
    busy_d    = busy;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    wen_d     = mem_wen;
    ack_d     = '0;
    err_d     = 1'b0;
    rdata_d   = m_rdata;
    flag_d    = timeout_flag & ~clr_flags;
    case (state_q)
      IDLE: begin
        if (!req8[grant]) burst_d = '0;
        if (|m_req) begin
          if (win != grant) burst_d = '0;
          grant_d   = win;
          have_d    = 1'b1;
          addr_d    = addr_a[win];
          wdata_d   = wd_a[win];
          wen_d     = wen8[win];
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          timer_d   = '0;
          drop_d    = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        drop_d = drop_now;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (grant == 3'(i)) && !drop_now;
          rdata_d   = mem_rdata;
          if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
          state_d   = GAP;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          for (int i = 0; i < N_REQ; i++) ack_d[i] = (grant == 3'(i)) && !drop_now;
          err_d     = ~drop_now;
          rdata_d   = '0;
          flag_d    = 1'b1;
          state_d   = GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      burst_q      <= '0;
      have_q       <= 1'b0;
      drop_q       <= 1'b0;
      grant        <= 3'(N_REQ - 1);
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wen      <= 1'b0;
      m_ack        <= '0;
      m_err        <= 1'b0;
      m_rdata      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      burst_q      <= burst_d;
      have_q       <= have_d;
      drop_q       <= drop_d;
      grant        <= grant_d;
      mem_req      <= mem_req_d;
      busy         <= busy_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      mem_wen      <= wen_d;
      m_ack        <= ack_d;
      m_err        <= err_d;
      m_rdata      <= rdata_d;
      timeout_flag <= flag_d;
    end
  end

endmodule

// File: tb/tb_mp64_dma_arb.sv
// Bench for mp64_dma_arb: directed vector table, multi-cycle corner sequences,
// then random traffic against a transaction-level arbitration model.
module tb_mp64_dma_arb;
  localparam int N  = 3;
  localparam int MB = 4;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    m_req = '0;
  logic [63:0]     p_addr [N];
  logic [7:0]      p_wd   [N];
  logic [N-1:0]    m_wen = '0;
  logic [64*N-1:0] m_addr;
  logic [8*N-1:0]  m_wdata;
  logic [N-1:0]    m_ack;
  logic            m_err, busy, timeout_flag, mem_req, mem_wen;
  logic            clr_flags = 1'b0;
  logic            mem_ack = 1'b0;
  logic [7:0]      m_rdata, mem_wdata;
  logic [7:0]      mem_rdata = '0;
  logic [2:0]      grant;
  logic [63:0]     mem_addr;

  always #5 clk = ~clk;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[64*i +: 64] = p_addr[i];
      m_wdata[8*i +: 8]  = p_wd[i];
    end
  end

  mp64_dma_arb #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wen(m_wen), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .grant(grant),
    .busy(busy), .timeout_flag(timeout_flag), .clr_flags(clr_flags),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [N-1:0] req, input logic [63:0] a,
                         input logic [7:0] wd, input logic wen);
    for (int i = 0; i < N; i++) begin
      p_addr[i] = a + 64'(i);
      p_wd[i]   = wd;
      m_wen[i]  = wen;
    end
    m_req = req;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [63:0]  addr;
    logic [7:0]   wd;
    logic         wen;
    logic         ack;
    logic [7:0]   rd;
    logic         e_mreq;
    logic [N-1:0] e_ack;
    logic         e_err;
    logic [7:0]   e_rdata;
    logic [2:0]   e_grant;
    logic [63:0]  e_addr;
    logic [7:0]   e_wd;
    logic         e_wen;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] req, input logic [63:0] addr, input logic [7:0] wd,
                              input logic wen, input logic ack, input logic [7:0] rd,
                              input logic e_mreq, input logic [N-1:0] e_ack, input logic e_err,
                              input logic [7:0] e_rdata, input logic [2:0] e_grant,
                              input logic [63:0] e_addr, input logic [7:0] e_wd, input logic e_wen);
    vec_t v;
    v.req = req; v.addr = addr; v.wd = wd; v.wen = wen; v.ack = ack; v.rd = rd;
    v.e_mreq = e_mreq; v.e_ack = e_ack; v.e_err = e_err; v.e_rdata = e_rdata;
    v.e_grant = e_grant; v.e_addr = e_addr; v.e_wd = e_wd; v.e_wen = e_wen;
    return v;
  endfunction

  // Reference model state for the random phase.
  int   last, cnt, mw, mport;
  bit   started, mb, mg, fl, tout;
  logic [63:0]  ea;
  logic [7:0]   ewd, er;
  logic         ewen, e_err;
  logic [N-1:0] e_ack;

  function automatic int winner(input logic [N-1:0] r);
    if (started && r[last] && cnt < MB) return last;
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    int   seq [$];
    int   ts  [$];
    int   exp_seq [10];
    int   n_high;
    bit   got;

    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    tbl[0]  = mk(3'b001, 64'h1000, 8'hA5, 1, 0, 8'h00, 1, 3'b000, 0, 8'h00, 3'd0, 64'h1000, 8'hA5, 1);
    tbl[1]  = mk(3'b001, 64'h1000, 8'hA5, 1, 1, 8'h77, 0, 3'b001, 0, 8'h77, 3'd0, 64'h0, 8'h00, 0);
    tbl[2]  = mk(3'b000, 64'h0,    8'h00, 0, 0, 8'h00, 0, 3'b000, 0, 8'h77, 3'd0, 64'h0, 8'h00, 0);
    tbl[3]  = mk(3'b010, 64'h1FFF, 8'h00, 0, 0, 8'h00, 1, 3'b000, 0, 8'h77, 3'd1, 64'h2000, 8'h00, 0);
    tbl[4]  = mk(3'b010, 64'h1FFF, 8'h00, 0, 1, 8'h3C, 0, 3'b010, 0, 8'h3C, 3'd1, 64'h0, 8'h00, 0);
    tbl[5]  = mk(3'b000, 64'h0,    8'h00, 0, 1, 8'hEE, 0, 3'b000, 0, 8'h3C, 3'd1, 64'h0, 8'h00, 0);
    tbl[6]  = mk(3'b000, 64'h0,    8'h00, 0, 1, 8'hEE, 0, 3'b000, 0, 8'h3C, 3'd1, 64'h0, 8'h00, 0);
    tbl[7]  = mk(3'b100, 64'h2FFE, 8'h5A, 1, 0, 8'h00, 1, 3'b000, 0, 8'h3C, 3'd2, 64'h3000, 8'h5A, 1);
    tbl[8]  = mk(3'b100, 64'h2FFE, 8'h5A, 1, 1, 8'h11, 0, 3'b100, 0, 8'h11, 3'd2, 64'h0, 8'h00, 0);
    tbl[9]  = mk(3'b011, 64'h1000, 8'h01, 0, 0, 8'h00, 0, 3'b000, 0, 8'h11, 3'd2, 64'h0, 8'h00, 0);
    tbl[10] = mk(3'b011, 64'h1000, 8'h01, 0, 0, 8'h00, 1, 3'b000, 0, 8'h11, 3'd0, 64'h1000, 8'h01, 0);
    tbl[11] = mk(3'b011, 64'h1000, 8'h01, 0, 1, 8'h22, 0, 3'b001, 0, 8'h22, 3'd0, 64'h0, 8'h00, 0);
    tbl[12] = mk(3'b000, 64'h0,    8'h00, 0, 0, 8'h00, 0, 3'b000, 0, 8'h22, 3'd0, 64'h0, 8'h00, 0);
    tbl[13] = mk(3'b000, 64'h0,    8'h00, 0, 0, 8'h00, 0, 3'b000, 0, 8'h22, 3'd0, 64'h0, 8'h00, 0);

    set_all('0, 64'h0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset m_ack", 64'(m_ack), 64'd0);
    chk("reset m_err", 64'(m_err), 64'd0);
    chk("reset m_rdata", 64'(m_rdata), 64'd0);
    chk("reset grant", 64'(grant), 64'(N - 1));
    chk("reset timeout_flag", 64'(timeout_flag), 64'd0);
    chk("reset mem_addr", mem_addr, 64'd0);
    chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
    chk("reset mem_wen", 64'(mem_wen), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_all(tbl[i].req, tbl[i].addr, tbl[i].wd, tbl[i].wen);
      mem_ack   = tbl[i].ack;
      mem_rdata = tbl[i].rd;
      cyc();
      chk($sformatf("vec%0d mem_req", i), 64'(mem_req), 64'(tbl[i].e_mreq));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].e_mreq));
      chk($sformatf("vec%0d m_ack", i), 64'(m_ack), 64'(tbl[i].e_ack));
      chk($sformatf("vec%0d m_err", i), 64'(m_err), 64'(tbl[i].e_err));
      chk($sformatf("vec%0d m_rdata", i), 64'(m_rdata), 64'(tbl[i].e_rdata));
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].e_grant));
      if (tbl[i].e_mreq) begin
        chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wd));
        chk($sformatf("vec%0d mem_wen", i), 64'(mem_wen), 64'(tbl[i].e_wen));
      end
    end
    mem_ack = 1'b0;

    // mem_ack lands in the same WAIT cycle that would time out: the ack wins.
    set_all(3'b001, 64'h4000, 8'h99, 1'b1);
    cyc();
    chk("coinc mem_req start", 64'(mem_req), 64'd1);
    repeat (9) cyc();
    chk("coinc mem_req before limit", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 8'h6B;
    cyc();
    mem_ack = 1'b0;
    chk("coinc m_ack", 64'(m_ack), 64'b001);
    chk("coinc m_err", 64'(m_err), 64'd0);
    chk("coinc m_rdata", 64'(m_rdata), 64'h6B);
    chk("coinc timeout_flag", 64'(timeout_flag), 64'd0);
    m_req = '0;
    repeat (2) cyc();

    // Withheld ack: abort after TO cycles of mem_req, sticky flag until clr_flags.
    set_all(3'b001, 64'h5000, 8'h42, 1'b0);
    n_high = 0;
    got    = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      cyc();
      if (m_ack != '0) got = 1'b1;
      else if (mem_req) n_high++;
    end
    chk("timeout reached", 64'(got), 64'd1);
    chk("timeout mem_req cycles", 64'(n_high), 64'(TO));
    chk("timeout m_ack", 64'(m_ack), 64'b001);
    chk("timeout m_err", 64'(m_err), 64'd1);
    chk("timeout m_rdata", 64'(m_rdata), 64'd0);
    chk("timeout mem_req", 64'(mem_req), 64'd0);
    chk("timeout flag set", 64'(timeout_flag), 64'd1);
    m_req = '0;
    repeat (5) cyc();
    chk("timeout flag sticky", 64'(timeout_flag), 64'd1);
    chk("timeout m_err pulse", 64'(m_err), 64'd0);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("timeout flag cleared", 64'(timeout_flag), 64'd0);
    cyc();

    // clr_flags in the same cycle as a new timeout: the set wins.
    set_all(3'b001, 64'h5100, 8'h43, 1'b1);
    repeat (10) cyc();
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("setwins m_err", 64'(m_err), 64'd1);
    chk("setwins flag", 64'(timeout_flag), 64'd1);
    m_req = '0;
    cyc();
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("setwins flag cleared", 64'(timeout_flag), 64'd0);
    cyc();

    // Requester withdraws mid-WAIT: memory completes but no m_ack is issued.
    set_all(3'b001, 64'h6000, 8'h01, 1'b0);
    cyc();
    chk("drop mem_req", 64'(mem_req), 64'd1);
    m_req = '0;
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("drop m_ack", 64'(m_ack), 64'd0);
    chk("drop mem_req done", 64'(mem_req), 64'd0);
    chk("drop busy", 64'(busy), 64'd0);
    repeat (2) cyc();

    // Reset while WAIT: mem_req falls without waiting for a clock edge.
    set_all(3'b010, 64'h7000, 8'h02, 1'b0);
    cyc();
    chk("rst grant before", 64'(grant), 64'd1);
    chk("rst mem_req before", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst mem_req async", 64'(mem_req), 64'd0);
    chk("rst busy async", 64'(busy), 64'd0);
    chk("rst grant async", 64'(grant), 64'(N - 1));
    mem_ack = 1'b1;
    repeat (2) cyc();
    chk("rst no m_ack", 64'(m_ack), 64'd0);
    mem_ack = 1'b0;
    rst     = 1'b0;

    // Two continuous requesters, zero-wait memory: bursts of MB, 3 cycles per transfer.
    set_all(3'b011, 64'h8000, 8'h10, 1'b1);
    for (int c = 0; c < 100 && seq.size() < 10; c++) begin
      mem_ack = mem_req;
      cyc();
      if (m_ack != '0) begin
        seq.push_back(int'(grant));
        ts.push_back(c);
      end
    end
    mem_ack = 1'b0;
    m_req   = '0;
    chk("burst ack count", 64'(seq.size()), 64'd10);
    for (int k = 0; k < seq.size() && k < 10; k++) begin
      chk($sformatf("burst grant%0d", k), 64'(seq[k]), 64'(exp_seq[k]));
      if (k > 0) chk($sformatf("burst spacing%0d", k), 64'(ts[k] - ts[k-1]), 64'd3);
    end
    repeat (3) cyc();

    // Random traffic against the reference model.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    last = N - 1; cnt = 0; started = 0; mb = 0; mg = 0; fl = 0; er = '0;
    mw = 0; mport = 0; ea = '0; ewd = '0; ewen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      cyc();
      e_ack = '0;
      e_err = 1'b0;
      tout  = 1'b0;
      if (mg) mg = 0;
      else if (mb) begin
        mw++;
        if (mem_ack) begin
          e_ack[mport] = 1'b1;
          er = mem_rdata;
          mb = 0; mg = 1;
          if (cnt < 255) cnt++;
        end else if (mw == TO) begin
          e_ack[mport] = 1'b1;
          e_err = 1'b1;
          er = '0;
          tout = 1; mb = 0; mg = 1;
        end
      end else begin
        if (started && !m_req[last]) cnt = 0;
        if (m_req != '0) begin
          int w;
          w = winner(m_req);
          if (w != last) cnt = 0;
          last = w; started = 1; mb = 1; mw = 0; mport = w;
          ea = p_addr[w]; ewd = p_wd[w]; ewen = m_wen[w];
        end
      end
      fl = tout ? 1'b1 : (clr_flags ? 1'b0 : fl);

      chk("rnd mem_req", 64'(mem_req), 64'(mb));
      chk("rnd busy", 64'(busy), 64'(mb));
      chk("rnd m_ack", 64'(m_ack), 64'(e_ack));
      chk("rnd m_err", 64'(m_err), 64'(e_err));
      chk("rnd m_rdata", 64'(m_rdata), 64'(er));
      chk("rnd grant", 64'(grant), 64'(last));
      chk("rnd timeout_flag", 64'(timeout_flag), 64'(fl));
      if (mb) begin
        chk("rnd mem_addr", mem_addr, ea);
        chk("rnd mem_wdata", 64'(mem_wdata), 64'(ewd));
        chk("rnd mem_wen", 64'(mem_wen), 64'(ewen));
      end

      for (int i = 0; i < N; i++) begin
        if (!m_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            m_req[i]  = 1'b1;
            p_addr[i] = {$urandom, $urandom};
            p_wd[i]   = 8'($urandom);
            m_wen[i]  = 1'($urandom);
          end
        end else if (e_ack[i]) begin
          m_req[i]  = 1'($urandom_range(0, 1));
          p_addr[i] = {$urandom, $urandom};
          p_wd[i]   = 8'($urandom);
          m_wen[i]  = 1'($urandom);
        end
      end
      mem_ack   = ($urandom_range(0, 9) < 3);
      mem_rdata = 8'($urandom);
      clr_flags = ($urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mp64_dma_arb.md
Name: mp64_dma_arb

Overview:
- Byte-wide DMA arbiter that shares one memory-bus DMA port between N requesters (port 0 = NIC RX, port 1 = NIC TX; further ports for future peripherals).
- Replaces ad-hoc sharing inside the NIC with round-robin arbitration, burst locking and an ack-timeout watchdog.
- Sits between peripheral DMA masters and the memory-bus DMA slave port.

Parameters:
- N_REQ, 2, number of requester ports (2..8).
- MAX_BURST, 16, maximum consecutive grants to one requester while others wait (1..255).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- m_req  in  N_REQ  per-requester request, level.
- m_addr  in  64*N_REQ  per-requester byte address; port i at [64*i+63:64*i].
- m_wdata  in  8*N_REQ  per-requester write data.
- m_wen  in  N_REQ  per-requester direction: 1 = write, 0 = read.
- m_ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- m_err  out  1  qualifies m_ack: 1 = transfer aborted by timeout.
- m_rdata  out  8  read data; valid when m_ack is high, shared by all ports.
- grant  out  3  index of the current or last granted port.
- busy  out  1  high while a memory transaction is outstanding.
- timeout_flag  out  1  sticky timeout indication; cleared only by clr_flags.
- clr_flags  in  1  synchronous clear of timeout_flag.
- mem_req  out  1  memory-bus request.
- mem_addr  out  64  memory-bus address.
- mem_wdata  out  8  memory-bus write data.
- mem_wen  out  1  memory-bus write enable.
- mem_rdata  in  8  memory-bus read data.
- mem_ack  in  1  memory-bus completion.

Behaviour:
- Reset values: all outputs 0; grant = N_REQ-1, so port 0 wins first; burst_cnt = 0; state IDLE.
- Outputs are registered. Memory-side address, data and write-enable are latched at grant and held stable until completion.
- Requester contract: hold m_req with m_addr, m_wdata and m_wen stable until m_ack. The requester may re-raise m_req on the cycle after m_ack.

State machine:
- IDLE: if any m_req is set, choose the winner, latch its addr/wdata/wen into mem_*, set mem_req=1 and busy=1, then go to WAIT. A request seen at edge t gives mem_req high after edge t, i.e. one cycle of latency.
- WAIT, on mem_ack: clear mem_req and busy; pulse m_ack[grant]=1 with m_err=0; capture m_rdata from mem_rdata (captured for writes as well, don't-care); increment burst_cnt, saturating at 255; go to GAP.
- WAIT, on timer reaching TIMEOUT without mem_ack: clear mem_req and busy; pulse m_ack[grant] with m_err=1; set m_rdata=0 and timeout_flag=1; go to GAP.
- WAIT, if m_req[grant] drops before mem_ack: the memory transaction still completes, but m_ack is suppressed for that transaction.
- GAP: one dead cycle in which m_req is ignored, because the requester's m_req is stale that cycle. Then go to IDLE.
- A mem_ack that arrives in IDLE or GAP is ignored.

Winner selection:
- If m_req[grant] is set and burst_cnt < MAX_BURST, the same port wins again (burst lock).
- Otherwise the winner is the first set m_req scanning grant+1, grant+2, … modulo N_REQ.
- Whenever grant changes, burst_cnt resets to 0.
- burst_cnt also resets when the granted port is seen idle in IDLE.
- With a single requester active, the burst limit is irrelevant: that port always wins after the rotation.

Timer:
- Cleared on entry to WAIT; counts each WAIT cycle.
- If mem_ack and the timeout occur in the same cycle, mem_ack wins and m_err=0.

Other edge cases:
- clr_flags and a new timeout in the same cycle: the flag is set (set wins).
- rst asserted mid-transaction: everything returns to reset values immediately, mem_req drops asynchronously, and no m_ack is issued.
- Throughput with zero-wait memory (mem_ack the cycle after mem_req): one transfer every 3 cycles per port.

Test Plan:
- Port 0 requests a write, addr 0x1000, data 0xA5, mem_ack one cycle after mem_req -> mem_req high the cycle after m_req, mem_addr=0x1000, mem_wdata=0xA5, mem_wen=1; m_ack[0] one cycle after mem_ack; m_err=0.
- Port 1 requests a read while memory returns 0x3C -> m_rdata=0x3C with m_ack[1]; grant=1.
- Both ports request continuously with MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,…; no port is starved.
- mem_ack withheld with TIMEOUT=10 -> mem_req drops after 10 WAIT cycles; m_ack pulses with m_err=1; timeout_flag stays 1 until clr_flags.
- rst asserted while in WAIT -> mem_req=0 immediately; no m_ack; after rst release, port 0 wins first.
- mem_ack and timeout in the same cycle; stray mem_ack in IDLE -> m_err=0 for the coincident case; the stray ack produces no m_ack.
